// File: rtl/tile_reveal_ctrl_if.sv
// tile_reveal_ctrl_if: game-side signals between the board driver (master) and the reveal controller (slave)
interface tile_reveal_ctrl_if #(
    parameter int GRID = 4,
    parameter int IDXW = 4
);
    localparam int N = GRID * GRID;
    logic            placement_done;
    logic [N-1:0]    mine_map;
    logic            mv_up;
    logic            mv_dn;
    logic            mv_lt;
    logic            mv_rt;
    logic            reveal_req;
    logic [IDXW-1:0] cursor_idx;
    logic [N-1:0]    revealed;
    logic            cnt_wr;
    logic [IDXW-1:0] cnt_idx;
    logic [3:0]      cnt_val;
    logic            busy;
    logic            game_over;
    logic            game_won;

    modport master (
        output placement_done, mine_map, mv_up, mv_dn, mv_lt, mv_rt, reveal_req,
        input  cursor_idx, revealed, cnt_wr, cnt_idx, cnt_val, busy, game_over, game_won
    );
    modport slave (
        input  placement_done, mine_map, mv_up, mv_dn, mv_lt, mv_rt, reveal_req,
        output cursor_idx, revealed, cnt_wr, cnt_idx, cnt_val, busy, game_over, game_won
    );
endinterface

// File: rtl/tile_reveal_ctrl.sv
// tile_reveal_ctrl: cursor/reveal FSM that counts the 8 neighbouring mines one per cycle
module tile_reveal_ctrl #(
    parameter int GRID = 4,
    parameter int IDXW = 4
) (
    input logic               clk,
    input logic               rst_n,
    tile_reveal_ctrl_if.slave bus
);
    localparam int N = GRID * GRID;
    typedef enum logic [2:0] {IDLE, PLAY, SCAN, REPORT, LOST, WON} state_t;
    state_t          state_q;
    logic [IDXW-1:0] row_q, col_q, srow_q, scol_q, cnt_idx_q;
    logic [2:0]      k_q;
    logic [3:0]      acc_q, cnt_val_q;
    logic [N-1:0]    revealed_q, new_bit;
    logic            cnt_wr_q, busy_q, over_q, won_q, hit, win;
    logic [IDXW-1:0] cur, sidx, nidx;
    int              dr, dc, nr, nc;

    assign cur     = IDXW'(int'(row_q) * GRID + int'(col_q));
    assign sidx    = IDXW'(int'(srow_q) * GRID + int'(scol_q));
    assign new_bit = {{(N-1){1'b0}}, 1'b1} << sidx;
    assign win     = $countones(revealed_q | new_bit) == N - $countones(bus.mine_map);

    // k walks NW,N,NE,W,E,SW,S,SE; off-board neighbours still cost their cycle
    always_comb begin
        dr   = (k_q < 3'd3) ? -1 : (k_q < 3'd5) ? 0 : 1;
        dc   = (k_q == 3'd0 || k_q == 3'd3 || k_q == 3'd5) ? -1 : (k_q == 3'd1 || k_q == 3'd6) ? 0 : 1;
        nr   = int'(srow_q) + dr;
        nc   = int'(scol_q) + dc;
        nidx = IDXW'(nr * GRID + nc);
        hit  = nr >= 0 && nr < GRID && nc >= 0 && nc < GRID && bus.mine_map[nidx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            srow_q     <= '0;
            scol_q     <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            revealed_q <= '0;
            cnt_wr_q   <= 1'b0;
            cnt_idx_q  <= '0;
            cnt_val_q  <= '0;
            busy_q     <= 1'b0;
            over_q     <= 1'b0;
            won_q      <= 1'b0;
        end else begin
            cnt_wr_q <= 1'b0;
            busy_q   <= state_q == SCAN || state_q == REPORT;
            over_q   <= state_q == LOST;
            won_q    <= state_q == WON;
            if (state_q != IDLE && !bus.placement_done) begin
                state_q    <= IDLE;
                row_q      <= '0;
                col_q      <= '0;
                revealed_q <= '0;
                busy_q     <= 1'b0;
                over_q     <= 1'b0;
                won_q      <= 1'b0;
            end else case (state_q)
                IDLE: state_q <= bus.placement_done ? PLAY : IDLE;
                PLAY: begin
                    row_q <= bus.mv_up ? (row_q != '0 ? row_q - 1'b1 : row_q)
                           : (bus.mv_dn && int'(row_q) < GRID - 1) ? row_q + 1'b1 : row_q;
                    col_q <= (bus.mv_up || bus.mv_dn) ? col_q
                           : bus.mv_lt ? (col_q != '0 ? col_q - 1'b1 : col_q)
                           : (bus.mv_rt && int'(col_q) < GRID - 1) ? col_q + 1'b1 : col_q;
                    if (bus.reveal_req && !revealed_q[cur]) begin
                        if (bus.mine_map[cur]) begin
                            revealed_q[cur] <= 1'b1;
                            state_q         <= LOST;
                        end else begin
                            srow_q  <= row_q;
                            scol_q  <= col_q;
                            acc_q   <= '0;
                            k_q     <= '0;
                            state_q <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    acc_q   <= acc_q + {3'b000, hit};
                    k_q     <= k_q + 1'b1;
                    state_q <= (k_q == 3'd7) ? REPORT : SCAN;
                end
                REPORT: begin
                    cnt_wr_q   <= 1'b1;
                    cnt_idx_q  <= sidx;
                    cnt_val_q  <= acc_q;
                    revealed_q <= revealed_q | new_bit;
                    state_q    <= win ? WON : PLAY;
                end
                default: state_q <= state_q;
            endcase
        end
    end

    assign bus.cursor_idx = cur;
    assign bus.revealed   = revealed_q;
    assign bus.cnt_wr     = cnt_wr_q;
    assign bus.cnt_idx    = cnt_idx_q;
    assign bus.cnt_val    = cnt_val_q;
    assign bus.busy       = busy_q;
    assign bus.game_over  = over_q;
    assign bus.game_won   = won_q;
endmodule

// File: tb/tb_tile_reveal_ctrl.sv
// tb_tile_reveal_ctrl: scenario tasks plus a randomized session run against a board-level reference model
module tb_tile_reveal_ctrl;
    localparam int GRID = 4;
    localparam int IDXW = 4;
    localparam int N    = GRID * GRID;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;

    int           m_row, m_col;
    logic [N-1:0] m_rev, m_map;
    bit           m_lost, m_won;

    tile_reveal_ctrl_if #(.GRID(GRID), .IDXW(IDXW)) bus ();
    tile_reveal_ctrl #(.GRID(GRID), .IDXW(IDXW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic int nb_count(logic [N-1:0] map, int r, int c);
        int n = 0;
        for (int i = -1; i <= 1; i++)
            for (int j = -1; j <= 1; j++)
                if ((i != 0 || j != 0) && r + i >= 0 && r + i < GRID && c + j >= 0 && c + j < GRID)
                    if (map[(r + i) * GRID + c + j]) n++;
        return n;
    endfunction

    task automatic model_move(bit up, bit dn, bit lt, bit rt);
        if (up) m_row = (m_row > 0) ? m_row - 1 : m_row;
        else if (dn) m_row = (m_row < GRID - 1) ? m_row + 1 : m_row;
        else if (lt) m_col = (m_col > 0) ? m_col - 1 : m_col;
        else if (rt) m_col = (m_col < GRID - 1) ? m_col + 1 : m_col;
    endtask

    task automatic drive(bit up, bit dn, bit lt, bit rt, bit rev);
        @(negedge clk);
        bus.mv_up = up; bus.mv_dn = dn; bus.mv_lt = lt; bus.mv_rt = rt; bus.reveal_req = rev;
        @(negedge clk);
        bus.mv_up = 0; bus.mv_dn = 0; bus.mv_lt = 0; bus.mv_rt = 0; bus.reveal_req = 0;
    endtask

    task automatic start_session(logic [N-1:0] map);
        @(negedge clk);
        bus.placement_done = 1'b0;
        @(negedge clk);
        bus.mine_map = map;
        bus.placement_done = 1'b1;
        @(negedge clk);
        m_map = map; m_row = 0; m_col = 0; m_rev = '0; m_lost = 0; m_won = 0;
    endtask

    task automatic wait_cnt_wr(output int lat);
        lat = -1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (bus.cnt_wr === 1'b1) begin
                lat = j;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bus.placement_done = 0; bus.mine_map = '0;
        bus.mv_up = 0; bus.mv_dn = 0; bus.mv_lt = 0; bus.mv_rt = 0; bus.reveal_req = 0;
        repeat (2) @(negedge clk);
        total++; if ({bus.cursor_idx, bus.revealed, bus.cnt_idx, bus.cnt_val} !== '0) $display("FAIL reset_regs: got %h want 0", {bus.cursor_idx, bus.revealed, bus.cnt_idx, bus.cnt_val}); else passed++;
        total++; if ({bus.cnt_wr, bus.busy, bus.game_over, bus.game_won} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {bus.cnt_wr, bus.busy, bus.game_over, bus.game_won}); else passed++;
        rst_n = 1'b1;
        drive(0, 1, 0, 1, 1);
        total++; if (bus.cursor_idx !== 4'd0 || bus.busy !== 1'b0) $display("FAIL idle_hold: cursor=%0d busy=%b want 0/0", bus.cursor_idx, bus.busy); else passed++;
    endtask

    task automatic test_edge_clamp;
        start_session(16'h0001);
        drive(1, 0, 0, 0, 0);
        total++; if (bus.cursor_idx !== 4'd0) $display("FAIL clamp_up: cursor=%0d want 0", bus.cursor_idx); else passed++;
        drive(0, 0, 1, 0, 0);
        total++; if (bus.cursor_idx !== 4'd0) $display("FAIL clamp_lt: cursor=%0d want 0", bus.cursor_idx); else passed++;
        repeat (4) drive(0, 0, 0, 1, 0);
        total++; if (bus.cursor_idx !== 4'd3) $display("FAIL clamp_rt: cursor=%0d want 3", bus.cursor_idx); else passed++;
        repeat (4) drive(0, 1, 0, 0, 0);
        total++; if (bus.cursor_idx !== 4'd15) $display("FAIL clamp_dn: cursor=%0d want 15", bus.cursor_idx); else passed++;
    endtask

    task automatic test_count;
        int lat;
        start_session(16'h0001);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        total++; if (bus.cursor_idx !== 4'd5) $display("FAIL count_cursor: cursor=%0d want 5", bus.cursor_idx); else passed++;
        drive(0, 0, 0, 0, 1);
        wait_cnt_wr(lat);
        total++; if (lat != 9) $display("FAIL count_latency: got %0d want 9", lat); else passed++;
        total++; if (bus.cnt_idx !== 4'd5 || bus.cnt_val !== 4'd1) $display("FAIL count_out: idx=%0d val=%0d want 5/1", bus.cnt_idx, bus.cnt_val); else passed++;
        total++; if (bus.revealed !== 16'h0020 || bus.busy !== 1'b1) $display("FAIL count_mask: rev=%h busy=%b want 0020/1", bus.revealed, bus.busy); else passed++;
        @(negedge clk);
        total++; if (bus.cnt_wr !== 1'b0 || bus.busy !== 1'b0 || bus.cnt_val !== 4'd1 || bus.game_won !== 1'b0) $display("FAIL count_after: wr=%b busy=%b val=%0d won=%b want 0/0/1/0", bus.cnt_wr, bus.busy, bus.cnt_val, bus.game_won); else passed++;
        drive(0, 0, 0, 0, 1);
        repeat (11) @(negedge clk);
        total++; if (bus.cnt_idx !== 4'd5 || bus.revealed !== 16'h0020) $display("FAIL rerevealed: idx=%0d rev=%h want 5/0020", bus.cnt_idx, bus.revealed); else passed++;
    endtask

    task automatic test_maps;
        int lat;
        start_session(16'h0550);
        drive(0, 0, 0, 0, 1);
        wait_cnt_wr(lat);
        total++; if (lat != 9 || bus.cnt_val !== 4'(nb_count(m_map, 0, 0))) $display("FAIL map0550: lat=%0d val=%0d want 9/%0d", lat, bus.cnt_val, nb_count(m_map, 0, 0)); else passed++;
        start_session(16'h0032);
        drive(0, 0, 0, 0, 1);
        wait_cnt_wr(lat);
        total++; if (lat != 9 || bus.cnt_val !== 4'd3) $display("FAIL map0032: lat=%0d val=%0d want 9/3", lat, bus.cnt_val); else passed++;
    endtask

    task automatic test_lost;
        bit seen = 0;
        start_session(16'h0001);
        drive(0, 0, 0, 0, 1);
        total++; if (bus.revealed !== 16'h0001 || bus.game_over !== 1'b0) $display("FAIL lost_edge: rev=%h over=%b want 0001/0", bus.revealed, bus.game_over); else passed++;
        @(negedge clk);
        total++; if (bus.game_over !== 1'b1) $display("FAIL lost_flag: over=%b want 1", bus.game_over); else passed++;
        drive(0, 1, 0, 1, 0);
        bus.reveal_req = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            bus.reveal_req = 1'b0;
            seen |= bus.cnt_wr | bus.busy;
        end
        total++; if (seen || bus.cursor_idx !== 4'd0 || bus.revealed !== 16'h0001 || bus.game_over !== 1'b1) $display("FAIL lost_frozen: act=%b cur=%0d rev=%h over=%b want 0/0/0001/1", seen, bus.cursor_idx, bus.revealed, bus.game_over); else passed++;
        bus.placement_done = 1'b0;
        @(negedge clk);
        total++; if (bus.game_over !== 1'b0 || bus.revealed !== 16'h0) $display("FAIL lost_clear: over=%b rev=%h want 0/0", bus.game_over, bus.revealed); else passed++;
    endtask

    task automatic test_won;
        int lat;
        start_session(16'hFFFE);
        drive(0, 0, 0, 0, 1);
        wait_cnt_wr(lat);
        total++; if (lat != 9 || bus.cnt_val !== 4'd3 || bus.game_won !== 1'b0) $display("FAIL won_count: lat=%0d val=%0d won=%b want 9/3/0", lat, bus.cnt_val, bus.game_won); else passed++;
        @(negedge clk);
        total++; if (bus.game_won !== 1'b1) $display("FAIL won_flag: won=%b want 1", bus.game_won); else passed++;
        drive(0, 0, 0, 1, 0);
        total++; if (bus.cursor_idx !== 4'd0 || bus.game_won !== 1'b1) $display("FAIL won_frozen: cur=%0d won=%b want 0/1", bus.cursor_idx, bus.game_won); else passed++;
        start_session(16'h0000);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        drive(1, 0, 0, 1, 0);
        total++; if (bus.cursor_idx !== 4'd1) $display("FAIL move_priority: cur=%0d want 1", bus.cursor_idx); else passed++;
        drive(0, 1, 1, 1, 0);
        total++; if (bus.cursor_idx !== 4'd5) $display("FAIL move_priority2: cur=%0d want 5", bus.cursor_idx); else passed++;
    endtask

    task automatic test_abort;
        bit seen = 0;
        start_session(16'h0001);
        drive(0, 1, 0, 1, 0);
        drive(0, 0, 0, 0, 1);
        repeat (3) @(negedge clk);
        bus.placement_done = 1'b0;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0 || bus.revealed !== 16'h0 || bus.cursor_idx !== 4'd0) $display("FAIL abort_state: busy=%b rev=%h cur=%0d want 0/0/0", bus.busy, bus.revealed, bus.cursor_idx); else passed++;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            seen |= bus.cnt_wr;
        end
        total++; if (seen) $display("FAIL abort_no_wr: cnt_wr seen=%b want 0", seen); else passed++;
    endtask

    task automatic test_async_reset;
        int lat;
        start_session(16'h0001);
        drive(0, 1, 0, 1, 0);
        drive(0, 0, 0, 0, 1);
        wait_cnt_wr(lat);
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.cursor_idx !== 4'd0 || bus.revealed !== 16'h0 || bus.cnt_val !== 4'd0 || bus.cnt_wr !== 1'b0) $display("FAIL async_reset: cur=%0d rev=%h val=%0d wr=%b want 0/0/0/0", bus.cursor_idx, bus.revealed, bus.cnt_val, bus.cnt_wr); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random;
        for (int s = 0; s < 6; s++) begin
            start_session(N'($urandom() & $urandom()));
            for (int op = 0; op < 25; op++) begin
                bit up, dn, lt, rt, rev, playing;
                int cur, lat;
                up = $urandom_range(0, 4) == 0;
                dn = $urandom_range(0, 2) == 0;
                lt = $urandom_range(0, 2) == 0;
                rt = $urandom_range(0, 2) == 0;
                rev = $urandom_range(0, 2) == 0;
                playing = !m_lost && !m_won;
                cur = m_row * GRID + m_col;
                drive(up, dn, lt, rt, rev);
                if (playing) model_move(up, dn, lt, rt);
                if (playing && rev && !m_rev[cur]) begin
                    m_rev[cur] = 1'b1;
                    if (m_map[cur]) begin
                        m_lost = 1;
                        total++; if (bus.revealed !== m_rev) $display("FAIL rnd_mine: rev=%h want %h", bus.revealed, m_rev); else passed++;
                        @(negedge clk);
                    end else begin
                        wait_cnt_wr(lat);
                        total++; if (lat != 9 || bus.cnt_idx !== IDXW'(cur) || bus.cnt_val !== 4'(nb_count(m_map, cur / GRID, cur % GRID))) $display("FAIL rnd_scan: lat=%0d idx=%0d val=%0d want 9/%0d/%0d", lat, bus.cnt_idx, bus.cnt_val, cur, nb_count(m_map, cur / GRID, cur % GRID)); else passed++;
                        if ($countones(m_rev) == N - $countones(m_map)) m_won = 1;
                        @(negedge clk);
                    end
                end
                total++; if (bus.cursor_idx !== IDXW'(m_row * GRID + m_col) || bus.revealed !== m_rev) $display("FAIL rnd_board: cur=%0d rev=%h want %0d/%h", bus.cursor_idx, bus.revealed, m_row * GRID + m_col, m_rev); else passed++;
                total++; if (bus.game_over !== m_lost || bus.game_won !== m_won) $display("FAIL rnd_flags: over=%b won=%b want %b/%b", bus.game_over, bus.game_won, m_lost, m_won); else passed++;
            end
        end
    endtask

    initial begin
        test_reset;
        test_edge_clamp;
        test_count;
        test_maps;
        test_lost;
        test_won;
        test_abort;
        test_async_reset;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
